rgb_pwm_fader: RTL
==================

// Module: rgb_pwm_fader
// PURPOSE
//  Downstream LED stage for the colour sequencer. Accepts an 8-bit-per-channel target colour
//  via valid/ready and drives the RGB pins with PWM. Duty ramps linearly from the current
//  colour to the target, giving smooth fades instead of hard on/off steps.
// PARAMETERS
//  PWM_BITS     8     duty / PWM counter width; PWM period = 2**PWM_BITS clk cycles
//  STEP_CYCLES  4096  clk cycles between fade steps (>=1)
//  FADE_STEP    1     max duty change per channel per fade step (>=1)
// PORTS
//  clk       in   1         system clock (12 MHz)
//  rst       in   1         synchronous reset, active-high
//  in_valid  in   1         target colour valid
//  in_ready  out  1         block can accept a target (state IDLE, rst low)
//  in_r      in   PWM_BITS  target red duty
//  in_g      in   PWM_BITS  target green duty
//  in_b      in   PWM_BITS  target blue duty
//  busy      out  1         fade in progress (state FADE)
//  RGB_R     out  1         red PWM pin
//  RGB_G     out  1         green PWM pin
//  RGB_B     out  1         blue PWM pin
// BEHAVIOUR
//  Reset (rst high at clk edge): state=IDLE; cur_*, tgt_*, act_*, pwm_cnt, step_cnt = 0;
//   pins = inactive level; busy=0. in_ready=0 while rst high, 1 the first cycle after.
//   Reset mid-fade abandons the fade; no partial state survives.
//  PWM: pwm_cnt free-runs 0..2**PWM_BITS-1, wraps to 0. Pin (registered, 1-cycle latency) is
//   active when pwm_cnt < act_x. act_x=0 -> never active; act_x=max -> active 255/256 (default).
//  Glitch-free: act_x <= cur_x only on the cycle pwm_cnt == max, so new duty takes effect at
//   period start.
//  FSM IDLE: in_ready=1. in_valid&&in_ready -> latch tgt_*=in_*, step_cnt=0, go FADE.
//   in_* is ignored when the handshake does not occur.
//  FSM FADE: in_ready=0, busy=1.
//   - If cur_*==tgt_* on all channels -> IDLE next cycle. Checked every cycle, before steps.
//   - Else step_cnt counts 0..STEP_CYCLES-1. At STEP_CYCLES-1 it wraps to 0, and each unequal
//     channel moves toward tgt by min(FADE_STEP,|tgt-cur|).
//   - No overshoot, no wrap. Arithmetic is done in PWM_BITS+1 bits.
//  Target equal to current: FADE for exactly 1 cycle, then IDLE (busy pulses 1 cycle).
//  Full fade 0->255 with FADE_STEP=1: 255*STEP_CYCLES cycles in FADE plus 1 compare cycle.
//  Channels fade independently. A channel that reaches its target holds while others continue.
// CONFIGURATION
//  RGB_ACTIVE_LOW_EN defined: pins active-low (active=0, inactive/reset=1) for direct
//   open-drain LED sinks.
//  Not defined: pins active-high (active=1, inactive/reset=0).
//  Only pin polarity changes; FSM, timing and handshake are identical.
// TESTING (PWM_BITS=8, STEP_CYCLES=4, FADE_STEP=1 unless noted)
//  1. Reset: hold rst 3 cycles -> pins inactive, busy=0, in_ready=0; cycle after rst low -> in_ready=1.
//  2. Send (255,0,0) from reset -> busy high for 255*4+1 cycles. Then red high 255 of 256 cycles per period; G,B never active.
//  3. From (100,100,100), send (104,96,100) -> R,G reach 104/96 after 16 cycles in FADE. B never changes. IDLE next cycle.
//  4. FADE_STEP=8, from 0 send (5,0,0) -> cur_r=5 after first step (clamped), then IDLE. No overshoot.
//  5. in_valid held high during FADE with changing data -> no accept until IDLE. The first accepted value is the one present on the IDLE cycle.
//  6. Assert rst mid-fade (cur_r=50) -> next cycle cur/act=0, pins inactive, state IDLE. Rerun 2 with RGB_ACTIVE_LOW_EN: pin levels inverted.

Source files
------------

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: LED output stage for the colour sequencer.
// Accepts a target colour over valid/ready and drives three PWM pins, ramping each
// channel's duty linearly from the current colour to the target.
// Build option: define RGB_ACTIVE_LOW_EN for active-low pins (open-drain LED sinks);
// otherwise the pins are active-high. Only the pin polarity differs between builds.
module rgb_pwm_fader #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 4096,
  parameter int FADE_STEP   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PWM_BITS-1:0] in_r,
  input  logic [PWM_BITS-1:0] in_g,
  input  logic [PWM_BITS-1:0] in_b,
  output logic                busy,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B
);

`ifdef RGB_ACTIVE_LOW_EN
  localparam logic PIN_ACTIVE = 1'b0;
`else
  localparam logic PIN_ACTIVE = 1'b1;
`endif

  localparam int SCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SCW-1:0] STEP_LAST = SCW'(STEP_CYCLES - 1);
  // A step larger than the full duty range behaves the same as the full range,
  // so clamp it to keep the (PWM_BITS+1)-bit arithmetic exact.
  localparam int FS_LIM = (FADE_STEP > (1 << PWM_BITS)) ? (1 << PWM_BITS) : FADE_STEP;
  localparam logic [PWM_BITS:0] FS = (PWM_BITS + 1)'(FS_LIM);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [PWM_BITS-1:0] cur_r, cur_g, cur_b;
  logic [PWM_BITS-1:0] tgt_r, tgt_g, tgt_b;
  logic [PWM_BITS-1:0] act_r, act_g, act_b;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SCW-1:0]      step_cnt, step_cnt_next;
  logic                accept;
  logic                step_fire;
  logic                all_equal;

  // Move cur toward tgt by at most FS without overshooting or wrapping.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS:0] c, t, d, mv, res;
    c   = {1'b0, cur};
    t   = {1'b0, tgt};
    d   = '0;
    mv  = '0;
    res = c;
    if (t > c) begin
      d   = t - c;
      mv  = (d < FS) ? d : FS;
      res = c + mv;
    end else if (c > t) begin
      d   = c - t;
      mv  = (d < FS) ? d : FS;
      res = c - mv;
    end
    return res[PWM_BITS-1:0];
  endfunction

  assign all_equal = (cur_r == tgt_r) && (cur_g == tgt_g) && (cur_b == tgt_b);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, handshake, and step-timer control.
  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    busy          = 1'b0;
    accept        = 1'b0;
    step_fire     = 1'b0;
    step_cnt_next = step_cnt;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          accept        = 1'b1;
          step_cnt_next = '0;
          state_next    = FADE;
        end
      end
      FADE: begin
        busy = 1'b1;
        // Completion is tested before any step so an equal target leaves after one cycle.
        if (all_equal) begin
          state_next = IDLE;
        end else if (step_cnt == STEP_LAST) begin
          step_cnt_next = '0;
          step_fire     = 1'b1;
        end else begin
          step_cnt_next = step_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Colour datapath: target latch, fade steps, step timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_r    <= '0;
      tgt_g    <= '0;
      tgt_b    <= '0;
      cur_r    <= '0;
      cur_g    <= '0;
      cur_b    <= '0;
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt_next;
      if (accept) begin
        tgt_r <= in_r;
        tgt_g <= in_g;
        tgt_b <= in_b;
      end
      if (step_fire) begin
        cur_r <= step_toward(cur_r, tgt_r);
        cur_g <= step_toward(cur_g, tgt_g);
        cur_b <= step_toward(cur_b, tgt_b);
      end
    end
  end

  // PWM counter, period-aligned duty reload, and registered pin drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      act_r   <= '0;
      act_g   <= '0;
      act_b   <= '0;
      RGB_R   <= ~PIN_ACTIVE;
      RGB_G   <= ~PIN_ACTIVE;
      RGB_B   <= ~PIN_ACTIVE;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) begin
        act_r <= cur_r;
        act_g <= cur_g;
        act_b <= cur_b;
      end
      RGB_R <= (pwm_cnt < act_r) ? PIN_ACTIVE : ~PIN_ACTIVE;
      RGB_G <= (pwm_cnt < act_g) ? PIN_ACTIVE : ~PIN_ACTIVE;
      RGB_B <= (pwm_cnt < act_b) ? PIN_ACTIVE : ~PIN_ACTIVE;
    end
  end

endmodule
